// File: rtl/checkbits_monitor.sv
// Watches a firmware checkpoint bus and steps through a list of expected codes,
// reporting pass, failure code, or timeout for each run armed by start_i.
module checkbits_monitor #(
    parameter int                            CHECK_W     = 16,
    parameter int                            NUM_STAGES  = 4,
    parameter logic [NUM_STAGES*CHECK_W-1:0] EXPECT_VEC  = '1,
    parameter logic [CHECK_W-1:0]            FAIL_CODE   = CHECK_W'(16'hBAD0),
    parameter int                            STABLE_CYC  = 4,
    parameter int                            TIMEOUT_CYC = 200000,
    parameter int                            TICK_CYC    = 1000,
    localparam int                           SW          = $clog2(NUM_STAGES + 1)
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start_i,
    input  logic [CHECK_W-1:0] checkbits_i,
    output logic [SW-1:0]      stage_o,
    output logic               busy_o,
    output logic               pass_o,
    output logic               fail_o,
    output logic               timeout_o,
    output logic               tick_o
);

    localparam logic [7:0]  STB     = 8'(STABLE_CYC);
    localparam logic [31:0] TO_CNT  = 32'(TIMEOUT_CYC);
    localparam logic [31:0] TK_LAST = 32'(TICK_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [SW-1:0]      r_stage, w_stage_nxt;
    logic [7:0]         r_stab, w_stab_nxt;
    logic [7:0]         r_fstab, w_fstab_nxt;
    logic [31:0]        r_cyc, w_cyc_nxt;
    logic [31:0]        r_tick, w_tick_nxt;
    logic [CHECK_W-1:0] w_exp_code;
    logic               w_match;
    logic               w_fail_match;

    // Code expected for the stage currently being waited on.
    always_comb begin
        w_exp_code = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (r_stage == SW'(k)) begin
                w_exp_code = EXPECT_VEC[k*CHECK_W +: CHECK_W];
            end
        end
    end

    assign w_match      = (checkbits_i == w_exp_code);
    assign w_fail_match = (checkbits_i == FAIL_CODE);

    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_stab_nxt  = r_stab;
        w_fstab_nxt = r_fstab;
        w_cyc_nxt   = r_cyc;
        w_tick_nxt  = r_tick;
        case (r_state)
            S_WAIT: begin
                w_cyc_nxt   = r_cyc + 32'd1;
                w_tick_nxt  = (r_tick == TK_LAST) ? 32'd0 : r_tick + 32'd1;
                w_stab_nxt  = w_match ? r_stab + 8'd1 : 8'd0;
                w_fstab_nxt = w_fail_match ? r_fstab + 8'd1 : 8'd0;
                // A stable failure code beats both a stage match and the timeout.
                if (w_fstab_nxt == STB) begin
                    w_state_nxt = S_FAIL;
                end else begin
                    if (w_stab_nxt == STB) begin
                        w_stab_nxt  = 8'd0;
                        w_stage_nxt = r_stage + 1'b1;
                        if (w_stage_nxt == SW'(NUM_STAGES)) begin
                            w_state_nxt = S_PASS;
                        end
                    end
                    if (w_state_nxt == S_WAIT && w_cyc_nxt == TO_CNT) begin
                        w_state_nxt = S_TIMEOUT;
                    end
                end
            end
            default: begin
                if (start_i) begin
                    w_state_nxt = S_WAIT;
                    w_stage_nxt = '0;
                    w_stab_nxt  = 8'd0;
                    w_fstab_nxt = 8'd0;
                    w_cyc_nxt   = 32'd0;
                    w_tick_nxt  = 32'd0;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_stab  <= 8'd0;
            r_fstab <= 8'd0;
            r_cyc   <= 32'd0;
            r_tick  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_stab  <= w_stab_nxt;
            r_fstab <= w_fstab_nxt;
            r_cyc   <= w_cyc_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    assign stage_o   = r_stage;
    assign busy_o    = (r_state == S_WAIT);
    assign pass_o    = (r_state == S_PASS);
    assign fail_o    = (r_state == S_FAIL);
    assign timeout_o = (r_state == S_TIMEOUT);
    assign tick_o    = (r_state == S_WAIT) && (r_tick == TK_LAST);

endmodule

// File: tb/tb_checkbits_monitor.sv
// Randomized and directed bench for checkbits_monitor against a run-length reference model.
module tb_checkbits_monitor;

    localparam int TO_C = 20000;
    localparam int TK_C = 100;
    localparam int STB  = 4;
    localparam int NS   = 4;
    localparam logic [63:0] EV = {16'hAB40, 16'hAB30, 16'hAB20, 16'hAB10};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cb;
    logic [2:0]  stage;
    logic        busy, pass, fail, tmo, tick;

    always #5 clk = ~clk;

    checkbits_monitor #(
        .CHECK_W(16), .NUM_STAGES(NS), .EXPECT_VEC(EV), .FAIL_CODE(16'hBAD0),
        .STABLE_CYC(STB), .TIMEOUT_CYC(TO_C), .TICK_CYC(TK_C)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .checkbits_i(cb),
        .stage_o(stage), .busy_o(busy), .pass_o(pass), .fail_o(fail),
        .timeout_o(tmo), .tick_o(tick)
    );

    int total = 0;
    int bad   = 0;

    // Model: 0 idle, 1 running, 2 pass, 3 fail, 4 timeout
    int   m_state, m_stage, m_run, m_frun, m_cyc;
    logic obs_tick, exp_tick;

    function automatic logic [15:0] code_of(input int s);
        case (s)
            0: return 16'hAB10;
            1: return 16'hAB20;
            2: return 16'hAB30;
            3: return 16'hAB40;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_stage = 0; m_run = 0; m_frun = 0; m_cyc = 0;
    endtask

    task automatic model_step(input logic st, input logic [15:0] c);
        if (m_state == 1) begin
            m_cyc++;
            m_run  = (c == code_of(m_stage)) ? m_run + 1 : 0;
            m_frun = (c == 16'hBAD0) ? m_frun + 1 : 0;
            if (m_frun >= STB) begin
                m_state = 3;
            end else begin
                if (m_run >= STB) begin
                    m_stage++;
                    m_run = 0;
                    if (m_stage == NS) m_state = 2;
                end
                if (m_state == 1 && m_cyc >= TO_C) m_state = 4;
            end
        end else if (st) begin
            m_state = 1; m_stage = 0; m_run = 0; m_frun = 0; m_cyc = 0;
        end
    endtask

    task automatic step(input logic st, input logic [15:0] c);
        start    = st;
        cb       = c;
        exp_tick = (m_state == 1) && (((m_cyc + 1) % TK_C) == 0);
        @(negedge clk);
        obs_tick = tick;
        @(posedge clk);
        model_step(st, c);
        #1;
        start = 1'b0;
    endtask

    function automatic logic [7:0] exp_vec();
        return {3'(m_stage), m_state == 1, m_state == 2, m_state == 3, m_state == 4, exp_tick};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {stage, busy, pass, fail, tmo, obs_tick};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cb = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({stage, busy, pass, fail, tmo, tick} !== 8'h00) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b", {stage, busy, pass, fail, tmo, tick}, 8'h00);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 16'hAB10);
            total++;
            if (obs_vec() !== exp_vec() || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_hold i=%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_pass_seq();
        step(1'b1, 16'h0);
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 6; j++) begin
                step(1'b0, code_of(s));
                total++;
                if (obs_vec() !== exp_vec()) begin
                    bad++;
                    $display("FAIL pass_seq s=%0d j=%0d got=%b want=%b", s, j, obs_vec(), exp_vec());
                end
                if (s == 3 && (j == 2 || j == 3)) begin
                    total++;
                    if (pass !== (j == 3)) begin
                        bad++;
                        $display("FAIL pass_edge j=%0d got=%b want=%b", j, pass, (j == 3));
                    end
                end
            end
        end
        total++;
        if ({pass, busy, stage} !== 5'b10100) begin
            bad++;
            $display("FAIL pass_final got=%b want=%b", {pass, busy, stage}, 5'b10100);
        end
    endtask

    task automatic test_glitch();
        logic [15:0] seq [8];
        seq = '{16'hAB10, 16'hAB10, 16'hAB10, 16'h1234, 16'hAB10, 16'hAB10, 16'hAB10, 16'hAB10};
        step(1'b1, 16'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, seq[i]);
            total++;
            if (obs_vec() !== exp_vec() || stage !== ((i == 7) ? 3'd1 : 3'd0)) begin
                bad++;
                $display("FAIL glitch i=%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_fail();
        step(1'b1, 16'h0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, (i < 4) ? 16'hAB10 : (i < 8) ? 16'hAB20 : (i < 12) ? 16'h0000 : 16'hBAD0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL fail_seq i=%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if ({fail, pass, busy, stage} !== 6'b100010) begin
            bad++;
            $display("FAIL fail_final got=%b want=%b", {fail, pass, busy, stage}, 6'b100010);
        end
    endtask

    task automatic test_start_in_wait();
        step(1'b1, 16'h0);
        for (int i = 0; i < 30; i++) begin
            step((i == 6), code_of(i / 6 < 4 ? i / 6 : 3));
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL start_in_wait i=%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
            if (i == 6) begin
                total++;
                if (stage !== 3'd1) begin
                    bad++;
                    $display("FAIL start_ignored got=%0d want=1", stage);
                end
            end
        end
        total++;
        if (pass !== 1'b1) begin
            bad++;
            $display("FAIL start_in_wait_pass got=%b want=1", pass);
        end
    endtask

    task automatic test_reset_midrun();
        step(1'b1, 16'h0);
        for (int i = 0; i < 14; i++) step(1'b0, code_of(i < 12 ? i / 4 : 3));
        total++;
        if (stage !== 3'd3 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midrun_stage got=%0d/%b want=3/1", stage, busy);
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({stage, busy, pass, fail, tmo, tick} !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got=%b want=%b", {stage, busy, pass, fail, tmo, tick}, 8'h00);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b0, 16'hAB40);
        step(1'b1, 16'h0);
        for (int i = 0; i < 24; i++) begin
            step(1'b0, code_of(i / 6));
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rerun i=%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (pass !== 1'b1) begin
            bad++;
            $display("FAIL rerun_pass got=%b want=1", pass);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 16'h0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, code_of(i / 4));
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL back_to_back i=%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_timeout();
        int ticks = 0;
        int hit   = -1;
        step(1'b1, 16'h0);
        for (int i = 0; i < TO_C + 5; i++) begin
            step(1'b0, 16'h0000);
            if (obs_tick === 1'b1) ticks++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL timeout_run i=%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
            if (tmo === 1'b1 && hit < 0) hit = i;
        end
        total++;
        if (ticks != 200 || hit != TO_C - 1) begin
            bad++;
            $display("FAIL timeout_count ticks=%0d at=%0d want ticks=200 at=%0d", ticks, hit, TO_C - 1);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            int n = 0;
            step(1'b1, 16'h0);
            while (m_state == 1 && n < 300) begin
                int kind = $urandom_range(0, 9);
                int len  = $urandom_range(1, 6);
                logic [15:0] c;
                case (kind)
                    0, 1, 2, 3, 4, 5: c = code_of(m_stage);
                    6: c = code_of((m_stage > 0) ? m_stage - 1 : 0);
                    7: c = 16'hBAD0;
                    default: c = 16'($urandom);
                endcase
                if (kind == 7 && len > 4) len = 4;
                for (int j = 0; j < len; j++) begin
                    step((kind == 9 && j == 0), c);
                    n++;
                    total++;
                    if (obs_vec() !== exp_vec()) begin
                        bad++;
                        $display("FAIL random r=%0d n=%0d got=%b want=%b", r, n, obs_vec(), exp_vec());
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pass_seq();
        test_glitch();
        test_fail();
        test_start_in_wait();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
